// File: rtl/mem_arbiter_if.sv
// Byte-wide memory bus between the arbiter (master) and the shared memory (slave).
// The memory answers read_en with a one-cycle ready pulse; writes take no handshake.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              memory_read_en;
  logic              memory_write_en;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_data_in,
    output memory_read_en,
    output memory_write_en,
    input  mem_data_out,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_data_in,
    input  memory_read_en,
    input  memory_write_en,
    output mem_data_out,
    output mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory between two requesters,
// with a watchdog that aborts reads the memory never acknowledges.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_done,
  output logic              p1_done,
  output logic              p0_err,
  output logic              p1_err,
  mem_arbiter_if.master     mem
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic       gnt;
  logic       last;
  logic       err;
  logic [7:0] cnt;

  logic       pick;
  logic       pick_we;
  logic       load;
  logic       capture;
  logic       expire;
  logic       count;

  // On a tie the port that was not granted last wins; otherwise the lone requester.
  assign pick    = (p0_req && p1_req) ? ~last : p1_req;
  assign pick_we = pick ? p1_we : p0_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    count      = 1'b0;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          load       = 1'b1;
          state_next = pick_we ? WRITE : READ;
        end
      end
      READ: begin
        if (mem.mem_ready) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (cnt == LAST_WAIT) begin
          expire     = 1'b1;
          state_next = RESP;
        end else begin
          count = 1'b1;
        end
      end
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the granted port's rdata register is touched; the other keeps its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt             <= 1'b0;
      last            <= 1'b1;
      err             <= 1'b0;
      cnt             <= 8'd0;
      mem.mem_addr    <= '0;
      mem.mem_data_in <= '0;
      p0_rdata        <= '0;
      p1_rdata        <= '0;
    end else begin
      if (load) begin
        gnt             <= pick;
        last            <= pick;
        cnt             <= 8'd0;
        mem.mem_addr    <= pick ? p1_addr : p0_addr;
        mem.mem_data_in <= pick ? p1_wdata : p0_wdata;
      end
      if (count) begin
        cnt <= cnt + 8'd1;
      end
      if (capture) begin
        err <= 1'b0;
        if (gnt) begin
          p1_rdata <= mem.mem_data_out;
        end else begin
          p0_rdata <= mem.mem_data_out;
        end
      end
      if (expire) begin
        err <= 1'b1;
        if (gnt) begin
          p1_rdata <= '0;
        end else begin
          p0_rdata <= '0;
        end
      end
      if (state == WRITE) begin
        err <= 1'b0;
      end
    end
  end

  assign mem.memory_read_en  = (state == READ);
  assign mem.memory_write_en = (state == WRITE);
  assign p0_done             = (state == RESP) && !gnt;
  assign p1_done             = (state == RESP) && gnt;
  assign p0_err              = p0_done && err;
  assign p1_err              = p1_done && err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push hand-computed
// responses per port; a monitor pops and compares on every done pulse.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         done_cyc;
    int         rd_cyc;
    int         wr_cyc;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              p0_req, p1_req;
  logic              p0_we, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              p0_done, p1_done;
  logic              p0_err, p1_err;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0_req   (p0_req),
    .p1_req   (p1_req),
    .p0_we    (p0_we),
    .p1_we    (p1_we),
    .p0_addr  (p0_addr),
    .p1_addr  (p1_addr),
    .p0_wdata (p0_wdata),
    .p1_wdata (p1_wdata),
    .p0_rdata (p0_rdata),
    .p1_rdata (p1_rdata),
    .p0_done  (p0_done),
    .p1_done  (p1_done),
    .p0_err   (p0_err),
    .p1_err   (p1_err),
    .mem      (bus.master)
  );

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] mem [256];
  bit         loaded = 1'b0;
  bit         responded = 1'b0;
  bit         last_valid = 1'b0;
  bit         last_was_read = 1'b0;
  logic [7:0] last_addr = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Registered memory; a repeated read of the same address with nothing in between never answers.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'hAB] <= 8'h1E;
      mem[8'h01] <= 8'h11;
      mem[8'h02] <= 8'h22;
      mem[8'h03] <= 8'h33;
      mem[8'h04] <= 8'h44;
      mem[8'h20] <= 8'h77;
      mem[8'h40] <= 8'h99;
      mem[8'h41] <= 8'h9A;
      mem[8'h50] <= 8'hA0;
      mem[8'h51] <= 8'hA1;
      mem[8'h52] <= 8'hA2;
      mem[8'h60] <= 8'hB0;
      bus.mem_ready    <= 1'b0;
      bus.mem_data_out <= 8'h00;
      loaded           <= 1'b1;
    end else begin
      bus.mem_ready <= 1'b0;
      if (bus.memory_write_en) begin
        mem[bus.mem_addr[7:0]] <= bus.mem_data_in;
        last_was_read          <= 1'b0;
      end
      if (bus.memory_read_en && !responded) begin
        responded <= 1'b1;
        if (!(last_valid && last_was_read && last_addr == bus.mem_addr[7:0])) begin
          bus.mem_ready    <= 1'b1;
          bus.mem_data_out <= mem[bus.mem_addr[7:0]];
        end
        last_addr     <= bus.mem_addr[7:0];
        last_was_read <= 1'b1;
        last_valid    <= 1'b1;
      end
      if (!bus.memory_read_en) responded <= 1'b0;
    end
  end

  // Monitor: sampled mid-cycle, pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      check_output("strobes_exclusive", {31'd0, bus.memory_read_en && bus.memory_write_en}, 32'd0);
      check_output("done_exclusive", {31'd0, p0_done && p1_done}, 32'd0);
      if (bus.memory_read_en)  rd_cnt++;
      if (bus.memory_write_en) wr_cnt++;
      if (p0_done) begin
        if (q0.size() == 0) begin
          check_output("unexpected_p0_done", {31'd0, p0_done}, 32'd0);
        end else begin
          e = q0.pop_front();
          check_output("p0_done_cycle", cyc, e.done_cyc);
          check_output("p0_err", {31'd0, p0_err}, {31'd0, e.err});
          check_output("p0_rdata", {24'd0, p0_rdata}, {24'd0, e.rdata});
          check_output("p0_read_strobes", rd_cnt, e.rd_cyc);
          check_output("p0_write_strobes", wr_cnt, e.wr_cyc);
        end
      end
      if (p1_done) begin
        if (q1.size() == 0) begin
          check_output("unexpected_p1_done", {31'd0, p1_done}, 32'd0);
        end else begin
          e = q1.pop_front();
          check_output("p1_done_cycle", cyc, e.done_cyc);
          check_output("p1_err", {31'd0, p1_err}, {31'd0, e.err});
          check_output("p1_rdata", {24'd0, p1_rdata}, {24'd0, e.rdata});
          check_output("p1_read_strobes", rd_cnt, e.rd_cyc);
          check_output("p1_write_strobes", wr_cnt, e.wr_cyc);
        end
      end
      if (p0_done || p1_done) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One transaction issued in the current cycle; lat is the done cycle relative to issue.
  task automatic apply_stimulus(input int port, input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [7:0] exp_rdata,
                                input logic exp_err, input int lat, input int exp_rd,
                                input int exp_wr, input bit keep);
    exp_t e;
    bit   seen;
    e.rdata    = exp_rdata;
    e.err      = exp_err;
    e.done_cyc = cyc + lat;
    e.rd_cyc   = exp_rd;
    e.wr_cyc   = exp_wr;
    if (port == 0) begin
      p0_we = we; p0_addr = {24'd0, addr}; p0_wdata = wdata; p0_req = 1'b1;
      q0.push_back(e);
    end else begin
      p1_we = we; p1_addr = {24'd0, addr}; p1_wdata = wdata; p1_req = 1'b1;
      q1.push_back(e);
    end
    seen = 1'b0;
    for (int w = 0; w < 100 && !seen; w++) begin
      @(negedge clk);
      seen = (port == 0) ? p0_done : p1_done;
    end
    if (!seen) check_output("done_wait", {31'd0, (port == 0) ? p0_done : p1_done}, 32'd1);
    tick();
    if (!keep) begin
      if (port == 0) p0_req = 1'b0;
      else           p1_req = 1'b0;
    end
  endtask

  initial begin
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    do_reset();
    $display("[TB] reset state");
    check_output("rst_read_en", {31'd0, bus.memory_read_en}, 32'd0);
    check_output("rst_write_en", {31'd0, bus.memory_write_en}, 32'd0);
    check_output("rst_done", {30'd0, p1_done, p0_done}, 32'd0);
    check_output("rst_err", {30'd0, p1_err, p0_err}, 32'd0);
    check_output("rst_rdata", {16'd0, p1_rdata, p0_rdata}, 32'd0);
    check_output("rst_mem_addr", bus.mem_addr, 32'd0);
    check_output("rst_mem_data_in", {24'd0, bus.mem_data_in}, 32'd0);

    $display("[TB] single read");
    apply_stimulus(0, 1'b0, 8'hAB, 8'h00, 8'h1E, 1'b0, 3, 2, 0, 1'b0);

    $display("[TB] write then read");
    apply_stimulus(1, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b0, 2, 0, 1, 1'b0);
    apply_stimulus(1, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 3, 2, 0, 1'b0);

    $display("[TB] tie-break after reset");
    do_reset();
    fork
      apply_stimulus(0, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0, 3, 2, 0, 1'b0);
      apply_stimulus(1, 1'b0, 8'h02, 8'h00, 8'h22, 1'b0, 7, 2, 0, 1'b0);
    join
    fork
      apply_stimulus(0, 1'b0, 8'h03, 8'h00, 8'h33, 1'b0, 3, 2, 0, 1'b0);
      apply_stimulus(1, 1'b0, 8'h04, 8'h00, 8'h44, 1'b0, 7, 2, 0, 1'b0);
    join
    check_output("hold_p0_rdata", {24'd0, p0_rdata}, 32'h33);
    check_output("hold_p1_rdata", {24'd0, p1_rdata}, 32'h44);

    $display("[TB] read timeout");
    apply_stimulus(0, 1'b0, 8'h20, 8'h00, 8'h77, 1'b0, 3, 2, 0, 1'b0);
    apply_stimulus(0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, TIMEOUT + 1, TIMEOUT, 0, 1'b0);

    $display("[TB] reset mid-read");
    p0_we = 1'b0; p0_addr = 32'h40; p0_req = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_read_en", {31'd0, bus.memory_read_en}, 32'd0);
    check_output("mid_rst_write_en", {31'd0, bus.memory_write_en}, 32'd0);
    check_output("mid_rst_done", {30'd0, p1_done, p0_done}, 32'd0);
    check_output("mid_rst_err", {30'd0, p1_err, p0_err}, 32'd0);
    check_output("mid_rst_rdata", {16'd0, p1_rdata, p0_rdata}, 32'd0);
    check_output("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    p0_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    apply_stimulus(0, 1'b0, 8'h41, 8'h00, 8'h9A, 1'b0, 3, 2, 0, 1'b0);

    $display("[TB] starvation");
    fork
      begin
        apply_stimulus(0, 1'b0, 8'h50, 8'h00, 8'hA0, 1'b0, 3, 2, 0, 1'b1);
        apply_stimulus(0, 1'b0, 8'h51, 8'h00, 8'hA1, 1'b0, 7, 2, 0, 1'b1);
        apply_stimulus(0, 1'b0, 8'h52, 8'h00, 8'hA2, 1'b0, 3, 2, 0, 1'b0);
      end
      begin
        tick();
        apply_stimulus(1, 1'b0, 8'h60, 8'h00, 8'hB0, 1'b0, 6, 2, 0, 1'b0);
      end
    join

    tick();
    tick();
    check_output("p0_queue_empty", q0.size(), 32'd0);
    check_output("p1_queue_empty", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single byte-wide memory (read_en/write_en/ready handshake) between the CPU fetch port and a second requester (load/store or loader/debug). Each transaction is one byte, either read or write. Simultaneous requests are served round-robin. A read whose `mem_ready` never arrives is aborted by a watchdog and reported as an error; this covers the memory's repeated-same-address read case.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 8: data width.
- `TIMEOUT`, default 15: maximum cycles `memory_read_en` stays high waiting for `mem_ready`. Legal range 2..255.

Ports:
- `clk`  in  1  — the single clock; all logic on its rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `p0_req`, `p1_req`  in  1  — request; held high until that port's `done`.
- `p0_we`, `p1_we`  in  1  — 1 = write, 0 = read; stable while `req` is high.
- `p0_addr`, `p1_addr`  in  ADDR_W  — byte address; stable while `req` is high.
- `p0_wdata`, `p1_wdata`  in  DATA_W  — write data; stable while `req` is high.
- `p0_rdata`, `p1_rdata`  out  DATA_W  — last read result for that port.
- `p0_done`, `p1_done`  out  1  — one-cycle completion pulse.
- `p0_err`, `p1_err`  out  1  — timeout flag; valid only while `done` is high.
- `mem_addr`  out  ADDR_W  — address to memory.
- `mem_data_in`  out  DATA_W  — write data to memory.
- `mem_data_out`  in  DATA_W  — read data from memory.
- `memory_read_en`  out  1  — read strobe.
- `memory_write_en`  out  1  — write strobe.
- `mem_ready`  in  1  — read data valid; one-cycle pulse from memory.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Pick the granted port.
  - Latch that port's addr, we and wdata into `mem_addr` and `mem_data_in`.
  - Go to READ if we = 0, else WRITE.
  - Clear the watchdog counter.
- Arbitration when only one `req` is high: grant that port.
- Arbitration when both are high: grant the port not granted last (`last` pointer).
  - `last` updates on each grant.
  - After reset, `last` = 1, so port 0 wins the first tie.
- READ:
  - `memory_read_en` = 1.
  - If `mem_ready` is sampled high: capture `mem_data_out` into the granted port's rdata register, err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: rdata register ← 0, err = 1, go to RESP.
  - Else: counter++.
- WRITE: `memory_write_en` = 1 for exactly one cycle, err = 0, then RESP.
- RESP:
  - Granted port's `done` = 1 for one cycle; `err` driven with it.
  - Both strobes are 0.
  - Next state is IDLE.
- Only the granted port's rdata register changes. Each rdata holds its value until that port's next read completes.
- Counter is 8 bits wide and never wraps, because the state exits at TIMEOUT-1.
- Strobes are never both high. At most one `done` is high in any cycle.
- `mem_addr` and `mem_data_in` hold their latched values outside transactions.
- Reset (asynchronous, any state, including mid-READ or mid-WRITE):
  - FSM → IDLE, `last` = 1, counter = 0.
  - All outputs → 0: strobes, done, err, rdata, `mem_addr`, `mem_data_in`.
  - An interrupted transaction gets no `done`; the requester reissues it.
- A `req` still high in the cycle after its `done` is a new request.

## Timing
- Cycle 0 is the cycle in which IDLE samples `req`.
- Read path:
  - Cycle 1: READ with `memory_read_en` = 1.
  - With registered memory: `mem_ready` high in cycle 2, RESP/`done` in cycle 3.
  - Read latency is 3 cycles.
- Write path: WRITE in cycle 1, `done` in cycle 2. Write latency is 2 cycles.
- Timeout: `memory_read_en` is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); `done` with err = 1 comes in cycle TIMEOUT+1.
- A `mem_ready` pulse outside READ is ignored.
- Back-to-back: a registered requester drops `req` in the cycle after `done`, so IDLE occupies one cycle between transactions. Minimum spacing is 4 cycles per read and 3 per write.
- `rdata` is valid from the `done` cycle onward.

## Test plan
- Read: memory[0xAB] = 0x1E; `p0_req` read from 0xAB at cycle 0 → `p0_done` in cycle 3, `p0_rdata` = 0x1E, `p0_err` = 0; `p1_done` never asserts.
- Write then read: p1 writes 0x5A to 0x10 → `p1_done` at cycle 2 with `memory_write_en` high exactly 1 cycle; then p1 reads 0x10 → `p1_rdata` = 0x5A.
- Tie-break: right after reset, both ports request reads (0x01 and 0x02) in the same cycle → p0 served first, then p1. A second tie → p0 served first again (since `last` = 1 after p1). Each rdata holds its own port's data.
- Timeout: with TIMEOUT = 15, p0 reads 0x20 twice with no intervening access; the second read gets no `mem_ready` → `memory_read_en` high 15 cycles, `p0_done` with `p0_err` = 1, `p0_rdata` = 0.
- Reset mid-read: assert `rst_n` = 0 in cycle 2 of a read → strobes, done, err, rdata and `mem_addr` go to 0 immediately. After release, a fresh p0 read completes normally in 3 cycles.
- Starvation check: p0 issues continuous reads while p1 requests once → p1 is granted at the next IDLE after its request; p0 is not served twice in a row while p1 waits.
